// File: rtl/dsp_multacc_dot_sequencer.sv
// Dot-product feeder/collector around a registered-input unsigned MAC DSP.
// Optional m_ovf wrap flag: define DOT_SEQ_OVF_FLAG_EN.
module dsp_multacc_dot_sequencer #(
    parameter int A_W     = 20,
    parameter int B_W     = 18,
    parameter int Z_W     = 38,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    input  logic             s_last,
    output logic [A_W-1:0]   mac_a,
    output logic [B_W-1:0]   mac_b,
    output logic             mac_load_acc,
    input  logic [Z_W-1:0]   mac_z,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [Z_W-1:0]   m_z,
    output logic [LEN_W-1:0] m_count
`ifdef DOT_SEQ_OVF_FLAG_EN
    ,
    output logic             m_ovf
`endif
);

    localparam int DW = $clog2(MAC_LAT + 1);
    localparam logic [DW-1:0] LAT = DW'(MAC_LAT);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        FEED,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             first;
    logic [LEN_W-1:0] beat_cnt;
    logic [DW-1:0]    drain_cnt;
    logic             beat;
    logic             slot_free;
    logic             capture;

    assign beat      = s_valid && s_ready;
    assign slot_free = !m_valid || m_ready;

    assign mac_a        = beat ? s_a : '0;
    assign mac_b        = beat ? s_b : '0;
    assign mac_load_acc = !(beat && first);

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        capture   = 1'b0;
        unique case (state)
            FEED: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == LAT && slot_free) begin
                    capture   = 1'b1;
                    state_nxt = FEED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FEED;
            first     <= 1'b1;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            m_valid   <= 1'b0;
            m_z       <= '0;
            m_count   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                first <= s_last;
                if (first) begin
                    beat_cnt <= LEN_W'(1);
                end else if (beat_cnt != CNT_MAX) begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
            end
            // counts edges since the last beat so mac_z has settled
            if (beat && s_last) begin
                drain_cnt <= DW'(1);
            end else if (state == DRAIN && drain_cnt != LAT) begin
                drain_cnt <= drain_cnt + DW'(1);
            end
            if (capture) begin
                m_valid <= 1'b1;
                m_z     <= mac_z;
                m_count <= beat_cnt;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef DOT_SEQ_OVF_FLAG_EN
    logic [Z_W-1:0]     z_prev;
    logic [MAC_LAT-1:0] ld_pipe;
    logic               frame_ovf;
    logic               wrap;

    // ld_pipe tracks which mac_z updates were accumulates, not restarts
    assign wrap = ld_pipe[MAC_LAT-1] && (mac_z < z_prev);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_prev    <= '0;
            ld_pipe   <= '0;
            frame_ovf <= 1'b0;
            m_ovf     <= 1'b0;
        end else begin
            z_prev  <= mac_z;
            ld_pipe <= {ld_pipe[MAC_LAT-2:0], mac_load_acc};
            if (beat && first) begin
                frame_ovf <= 1'b0;
            end else if (wrap) begin
                frame_ovf <= 1'b1;
            end
            if (capture) begin
                m_ovf <= frame_ovf | wrap;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_multacc_dot_sequencer.sv
// Bench: DSP model plus frame-level expected-result queue, random and directed frames.
module tb_dsp_multacc_dot_sequencer;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int Z_W = 38;
    localparam int LEN_W = 8;
    localparam logic [63:0] ZMOD = 64'h40_0000_0000;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [A_W-1:0]   s_a;
    logic [B_W-1:0]   s_b;
    logic             s_last;
    logic [A_W-1:0]   mac_a;
    logic [B_W-1:0]   mac_b;
    logic             mac_load_acc;
    logic [Z_W-1:0]   mac_z;
    logic             m_valid;
    wire              m_ready;
    logic [Z_W-1:0]   m_z;
    logic [LEN_W-1:0] m_count;
`ifdef DOT_SEQ_OVF_FLAG_EN
    logic             m_ovf;
`endif

    logic fixed_rdy;
    logic rand_rdy;
    logic rnd_bit;
    assign m_ready = rand_rdy ? rnd_bit : fixed_rdy;

    int checks = 0;
    int errors = 0;

    dsp_multacc_dot_sequencer dut (
        .clk          (clk),
        .reset        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .s_last       (s_last),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_load_acc (mac_load_acc),
        .mac_z        (mac_z),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_z          (m_z),
        .m_count      (m_count)
`ifdef DOT_SEQ_OVF_FLAG_EN
        ,
        .m_ovf        (m_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom);

    // DSP model: a/b/load_acc registered, accumulator updated the next edge
    logic [A_W-1:0] a_r = '0;
    logic [B_W-1:0] b_r = '0;
    logic           ld_r = 1'b0;
    logic [Z_W-1:0] acc = '0;
    always @(posedge clk) begin
        a_r  <= mac_a;
        b_r  <= mac_b;
        ld_r <= mac_load_acc;
        acc  <= ld_r ? acc + Z_W'(a_r) * Z_W'(b_r) : Z_W'(a_r) * Z_W'(b_r);
    end
    assign mac_z = acc;

    typedef struct packed {
        logic [Z_W-1:0]   z;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
    } res_t;

    res_t        exp_q[$];
    logic        first_m = 1'b1;
    logic [63:0] sum_m = '0;
    int          cnt_m = 0;
    logic        ovf_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame-level reference: dot product of accepted pairs, mod 2^Z_W
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            first_m = 1'b1;
            sum_m   = '0;
            cnt_m   = 0;
            ovf_m   = 1'b0;
        end else if (s_valid && s_ready) begin
            logic [63:0] prod;
            prod = 64'(s_a) * 64'(s_b);
            if (first_m) begin
                sum_m = prod;
                cnt_m = 1;
                ovf_m = 1'b0;
            end else begin
                if (sum_m + prod >= ZMOD) ovf_m = 1'b1;
                sum_m = (sum_m + prod) % ZMOD;
                cnt_m = cnt_m + 1;
            end
            first_m = s_last;
            if (s_last) begin
                res_t r;
                r.z   = Z_W'(sum_m);
                r.cnt = (cnt_m > 255) ? 8'hFF : LEN_W'(cnt_m);
                r.ovf = ovf_m;
                exp_q.push_back(r);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic bt;
            bt = s_valid && s_ready;
            chk("mac_a", 64'(mac_a), bt ? 64'(s_a) : 64'd0);
            chk("mac_b", 64'(mac_b), bt ? 64'(s_b) : 64'd0);
            chk("mac_load_acc", 64'(mac_load_acc), 64'(!(bt && first_m)));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(m_z), 64'hDEAD);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("m_z", 64'(m_z), 64'(r.z));
                    chk("m_count", 64'(m_count), 64'(r.cnt));
`ifdef DOT_SEQ_OVF_FLAG_EN
                    chk("m_ovf", 64'(m_ovf), 64'(r.ovf));
`endif
                end
            end
        end
    end

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_a       = '0;
        s_b       = '0;
        s_last    = 1'b0;
        fixed_rdy = 1'b1;
        rand_rdy  = 1'b0;
        #12;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_z", 64'(m_z), 64'd0);
        chk("rst_m_count", 64'(m_count), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_load_acc", 64'(mac_load_acc), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three-beat frame and output latency
        send(20'd3, 18'd4, 1'b0);
        send(20'd5, 18'd6, 1'b0);
        send(20'd7, 18'd8, 1'b1);
        chk("t1_lat0", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_lat1", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_valid", 64'(m_valid), 64'd1);
        chk("t1_z", 64'(m_z), 64'd98);
        chk("t1_count", 64'(m_count), 64'd3);

        // single-beat full-scale frame restarts the accumulator
        s_valid = 1'b1;
        s_a     = 20'hFFFFF;
        s_b     = 18'h3FFFF;
        s_last  = 1'b1;
        @(negedge clk);
        chk("t2_s_ready", 64'(s_ready), 64'd1);
        chk("t2_load_acc", 64'(mac_load_acc), 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_z", 64'(m_z), 64'h3F_FFEC_0001);
        chk("t2_count", 64'(m_count), 64'd1);
        idle(2);

        // back-to-back frames with the result held by backpressure
        fixed_rdy = 1'b0;
        send(20'd2, 18'd2, 1'b1);
        send(20'd1, 18'd1, 1'b0);
        send(20'd1, 18'd1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_drain_s_ready", 64'(s_ready), 64'd0);
        chk("t3_hold_valid", 64'(m_valid), 64'd1);
        chk("t3_hold_z", 64'(m_z), 64'd4);
        fixed_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_second_valid", 64'(m_valid), 64'd1);
        chk("t3_second_z", 64'(m_z), 64'd2);
        chk("t3_second_count", 64'(m_count), 64'd2);
        idle(2);

        // idle gaps inside a frame
        send(20'd2, 18'd3, 1'b0);
        idle(3);
        send(20'd4, 18'd5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_z", 64'(m_z), 64'd26);
        idle(3);

        // reset mid-frame discards the partial frame
        send(20'd7, 18'd7, 1'b0);
        send(20'd9, 18'd9, 1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(20'd1, 18'd9, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_z", 64'(m_z), 64'd9);
        chk("t5_count", 64'(m_count), 64'd1);
        idle(2);

`ifdef DOT_SEQ_OVF_FLAG_EN
        send(20'hFFFFF, 18'h3FFFF, 1'b0);
        send(20'hFFFFF, 18'h3FFFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_ovf_set", 64'(m_ovf), 64'd1);
        send(20'd1, 18'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_ovf_clear", 64'(m_ovf), 64'd0);
        idle(2);
`endif

        // randomized frames, gaps and result backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(20'($urandom), 18'($urandom), i == len - 1);
            end
        end

        // long frame: m_count saturates
        for (int i = 0; i < 300; i++) begin
            send(20'($urandom_range(0, 15)), 18'($urandom_range(0, 15)), i == 299);
        end

        rand_rdy  = 1'b0;
        fixed_rdy = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_m_valid", 64'(m_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
